// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/add/sub, shift-add multiply over WIDTH cycles.
// Optional build macro SEQ_ALU_SATURATE_EN clamps add/mul overflow and sub borrow.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic [1:0]       state_dbg
);

`ifdef SEQ_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;
  logic               last_iter;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     dif_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_c;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, so accept and hand-off never share an edge.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;

  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = (op == 4'd1) ? MUL : DONE;
      MUL:     if (last_iter) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sum_w   = {1'b0, a} + {1'b0, b};
    dif_w   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = a;
    alu_c   = 1'b0;
    case (op)
      4'd0: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        if (SAT && alu_c) alu_res = '1;
      end
      4'd2: alu_res = a & b;
      4'd3: alu_res = a | b;
      4'd4: alu_res = ~a;
      4'd5: begin
        alu_res = dif_w[WIDTH-1:0];
        alu_c   = dif_w[WIDTH];
        // Carry low means a borrow occurred, so the saturated result is zero.
        if (SAT && !alu_c) alu_res = '0;
      end
      default: alu_res = a;
    endcase
  end

  always_comb begin
    mul_res = acc_next[WIDTH-1:0];
    mul_c   = |acc_next[2*WIDTH-1:WIDTH];
    if (SAT && mul_c) mul_res = '1;
  end

  // The final iteration folds its partial product straight into the registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == 4'd1) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              result <= alu_res;
              carry  <= alu_c;
              zero   <= (alu_res == '0);
            end
          end
        end
        MUL: begin
          if (last_iter) begin
            result <= mul_res;
            carry  <= mul_c;
            zero   <= (mul_res == '0);
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH = 8: directed cases, reset mid-multiply, random ops.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = 4'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic [1:0] state_dbg;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: {result, carry, zero}
  function automatic logic [9:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int unsigned s;
    logic [7:0] r;
    logic c;
    r = x;
    c = 1'b0;
    case (o)
      4'd0: begin s = x + y; c = (s > 255); r = s[7:0]; end
      4'd1: begin s = x * y; c = (s > 255); r = s[7:0]; end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = ~x;
      4'd5: begin c = (x >= y); s = (x - y) & 32'hFF; r = s[7:0]; end
      default: r = x;
    endcase
`ifdef SEQ_ALU_SATURATE_EN
    if ((o == 4'd0 || o == 4'd1) && c) r = 8'hFF;
    if (o == 4'd5 && !c) r = 8'h00;
`endif
    return {r, c, (r == 8'h00)};
  endfunction

  // Drive one operation; returns just after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(model(o, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, optionally stall hold cycles with a competing request, then take it.
  task automatic collect(input string tag, input int exp_lat, input int hold);
    int lat = 1;
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    logic [9:0] snap;
    logic [9:0] e;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
      snap = {result, carry, zero};
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; op = 4'd0; a = 8'h01; b = 8'h01;
        @(posedge clk); #1;
        if ({result, carry, zero} !== snap || in_ready || !out_valid) hold_ok = 1'b0;
      end
      in_valid = 1'b0;
      if (hold > 0) check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
      if (exp_q.size() == 0) begin
        check({tag, "_q_empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check(tag, {22'd0, result, carry, zero}, {22'd0, e});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_rdy"}, {30'd0, in_ready, out_valid}, 32'd2);
    end
  endtask

  initial begin
    logic [3:0] ro;
    logic [7:0] ra;
    logic [7:0] rb;
    #12;
    check("reset_out", {20'd0, result, carry, zero, out_valid, in_ready}, 32'h001);
    @(negedge clk);
    rst_n = 1'b1;

    send(4'd0, 8'h01, 8'h01);  collect("add", 1, 0);
    send(4'd0, 8'hFF, 8'h01);  collect("add_ovf", 1, 0);
    send(4'd1, 8'h02, 8'h03);  collect("mul", 9, 0);
    send(4'd1, 8'h10, 8'h10);  collect("mul_ovf", 9, 0);
    send(4'd2, 8'h06, 8'h05);  collect("and_bp", 1, 5);

    // Reset during the third multiply iteration discards the operation.
    send(4'd1, 8'h37, 8'h5B);
    void'(exp_q.pop_back());
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mul", {20'd0, result, carry, zero, out_valid, in_ready}, 32'h001);
    @(negedge clk);
    rst_n = 1'b1;
    send(4'd4, 8'h08, 8'h00);  collect("not", 1, 0);

    send(4'd5, 8'h03, 8'h05);  collect("sub", 1, 0);
    send(4'd5, 8'h09, 8'h04);  collect("sub_nb", 1, 0);
    send(4'd3, 8'hA0, 8'h05);  collect("or", 1, 0);
    send(4'hF, 8'h01, 8'h03);  collect("pass", 1, 0);
    send(4'd1, 8'hFF, 8'h01);  collect("mul_ff", 9, 0);

    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(ro, ra, rb);
      collect("rand", (ro == 4'd1) ? 9 : 1, $urandom_range(0, 2));
    end

    check("q_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
